// File: rtl/sht40_i2c_responder.sv
// sht40_i2c_responder
//   I2C target that stands in for an SHT40-style sensor. It accepts a
//   one-byte command write and returns a 6-byte measurement on read. SCL and
//   SDA are oversampled on clk, and SDA is driven open-drain through sda_oe.
// Ports:
//   clk        system clock, rising edge
//   rst_n      asynchronous active-low reset
//   scl_in     raw SCL line level
//   sda_in     raw SDA line level
//   sda_oe     1 = pull SDA low, 0 = release
//   rd_data    measurement bytes, [47:40] sent first
//   cmd_byte   last command byte received
//   cmd_valid  one-cycle pulse when cmd_byte updates
//   rd_done    one-cycle pulse when a read transaction ends
//   busy       high whenever the FSM is not idle
module sht40_i2c_responder #(
  parameter logic [6:0] ADDR = 7'h44
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        scl_in,
  input  logic        sda_in,
  output logic        sda_oe,
  input  logic [47:0] rd_data,
  output logic [7:0]  cmd_byte,
  output logic        cmd_valid,
  output logic        rd_done,
  output logic        busy
);

  localparam int unsigned DATA_W  = 48;
  localparam int unsigned CNT_W   = 3;
  localparam int unsigned SHIFT_W = 7;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ADDR,
    ST_ADDR_ACK,
    ST_WRITE,
    ST_WRITE_ACK,
    ST_READ,
    ST_READ_ACK,
    ST_WAIT_STOP
  } state_t;

  // Two-flop synchronizers plus a delayed copy for edge detection.
  logic r_scl_s1, r_scl_s2, r_scl_d;
  logic r_sda_s1, r_sda_s2, r_sda_d;

  // Registered bus events, one cycle after the synchronized edge.
  logic r_scl_rise, r_scl_fall, r_start, r_stop, r_sda_smp;

  state_t              r_state;
  logic [CNT_W-1:0]    r_bit_cnt;
  logic [CNT_W-1:0]    r_byte_cnt;
  logic [SHIFT_W-1:0]  r_shift;
  logic [DATA_W-1:0]   r_rd_sr;
  logic                r_rw;
  // ACK slots: set after the first fall (driving ACK) or, in READ_ACK,
  // after the master ACKed and another byte is due.
  logic                r_ack_phase;
  logic                r_sda_oe;
  logic [7:0]          r_cmd_byte;
  logic                r_cmd_valid;
  logic                r_rd_done;
  logic                r_busy;

  // Synchronizers reset to the idle-bus level.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_scl_s1 <= 1'b1;
      r_scl_s2 <= 1'b1;
      r_scl_d  <= 1'b1;
      r_sda_s1 <= 1'b1;
      r_sda_s2 <= 1'b1;
      r_sda_d  <= 1'b1;
    end else begin
      r_scl_s1 <= scl_in;
      r_scl_s2 <= r_scl_s1;
      r_scl_d  <= r_scl_s2;
      r_sda_s1 <= sda_in;
      r_sda_s2 <= r_sda_s1;
      r_sda_d  <= r_sda_s2;
    end
  end

  // Edge register: START/STOP only when SCL is steadily high.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_scl_rise <= 1'b0;
      r_scl_fall <= 1'b0;
      r_start    <= 1'b0;
      r_stop     <= 1'b0;
      r_sda_smp  <= 1'b1;
    end else begin
      r_scl_rise <= r_scl_s2 & ~r_scl_d;
      r_scl_fall <= ~r_scl_s2 & r_scl_d;
      r_start    <= r_scl_s2 & r_scl_d & ~r_sda_s2 & r_sda_d;
      r_stop     <= r_scl_s2 & r_scl_d & r_sda_s2 & ~r_sda_d;
      r_sda_smp  <= r_sda_s2;
    end
  end

  // Protocol FSM; START/STOP take priority over any SCL edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_bit_cnt   <= '0;
      r_byte_cnt  <= '0;
      r_shift     <= '0;
      r_rd_sr     <= '0;
      r_rw        <= 1'b0;
      r_ack_phase <= 1'b0;
      r_sda_oe    <= 1'b0;
      r_cmd_byte  <= 8'h00;
      r_cmd_valid <= 1'b0;
      r_rd_done   <= 1'b0;
      r_busy      <= 1'b0;
    end else begin
      r_cmd_valid <= 1'b0;
      r_rd_done   <= 1'b0;
      if (r_stop) begin
        r_state     <= ST_IDLE;
        r_bit_cnt   <= '0;
        r_ack_phase <= 1'b0;
        r_sda_oe    <= 1'b0;
        r_busy      <= 1'b0;
      end else if (r_start) begin
        r_state     <= ST_ADDR;
        r_bit_cnt   <= '0;
        r_ack_phase <= 1'b0;
        r_sda_oe    <= 1'b0;
        r_busy      <= 1'b1;
      end else begin
        case (r_state)
          ST_IDLE: begin
            r_sda_oe <= 1'b0;
          end

          ST_ADDR: begin
            if (r_scl_rise) begin
              r_shift   <= {r_shift[SHIFT_W-2:0], r_sda_smp};
              r_bit_cnt <= r_bit_cnt + CNT_W'(1);
              if (r_bit_cnt == CNT_W'(7)) begin
                if (r_shift == ADDR) begin
                  r_state     <= ST_ADDR_ACK;
                  r_ack_phase <= 1'b0;
                  r_rw        <= r_sda_smp;
                  if (r_sda_smp) begin
                    r_rd_sr    <= rd_data;
                    r_byte_cnt <= '0;
                  end
                end else begin
                  r_state <= ST_WAIT_STOP;
                end
              end
            end
          end

          ST_ADDR_ACK: begin
            if (r_scl_fall) begin
              if (!r_ack_phase) begin
                r_sda_oe    <= 1'b1;
                r_ack_phase <= 1'b1;
              end else begin
                r_ack_phase <= 1'b0;
                r_bit_cnt   <= '0;
                if (r_rw) begin
                  r_sda_oe <= ~r_rd_sr[DATA_W-1];
                  r_state  <= ST_READ;
                end else begin
                  r_sda_oe <= 1'b0;
                  r_state  <= ST_WRITE;
                end
              end
            end
          end

          ST_WRITE: begin
            if (r_scl_rise) begin
              r_shift   <= {r_shift[SHIFT_W-2:0], r_sda_smp};
              r_bit_cnt <= r_bit_cnt + CNT_W'(1);
              if (r_bit_cnt == CNT_W'(7)) begin
                r_cmd_byte  <= {r_shift, r_sda_smp};
                r_cmd_valid <= 1'b1;
                r_state     <= ST_WRITE_ACK;
                r_ack_phase <= 1'b0;
              end
            end
          end

          ST_WRITE_ACK: begin
            if (r_scl_fall) begin
              if (!r_ack_phase) begin
                r_sda_oe    <= 1'b1;
                r_ack_phase <= 1'b1;
              end else begin
                r_sda_oe    <= 1'b0;
                r_ack_phase <= 1'b0;
                r_bit_cnt   <= '0;
                r_state     <= ST_WRITE;
              end
            end
          end

          // Bit 47 of the shift register is always the bit on the wire.
          ST_READ: begin
            if (r_scl_fall) begin
              r_rd_sr   <= {r_rd_sr[DATA_W-2:0], 1'b0};
              r_bit_cnt <= r_bit_cnt + CNT_W'(1);
              if (r_bit_cnt == CNT_W'(7)) begin
                r_sda_oe    <= 1'b0;
                r_ack_phase <= 1'b0;
                r_state     <= ST_READ_ACK;
              end else begin
                r_sda_oe <= ~r_rd_sr[DATA_W-2];
              end
            end
          end

          ST_READ_ACK: begin
            if (r_scl_rise && !r_ack_phase) begin
              if (!r_sda_smp && (r_byte_cnt < CNT_W'(5))) begin
                r_byte_cnt  <= r_byte_cnt + CNT_W'(1);
                r_ack_phase <= 1'b1;
              end else begin
                r_rd_done <= 1'b1;
                r_sda_oe  <= 1'b0;
                r_state   <= ST_WAIT_STOP;
              end
            end else if (r_scl_fall && r_ack_phase) begin
              r_ack_phase <= 1'b0;
              r_bit_cnt   <= '0;
              r_sda_oe    <= ~r_rd_sr[DATA_W-1];
              r_state     <= ST_READ;
            end
          end

          ST_WAIT_STOP: begin
            r_sda_oe <= 1'b0;
          end

          default: begin
            r_state  <= ST_IDLE;
            r_sda_oe <= 1'b0;
          end
        endcase
      end
    end
  end

  assign sda_oe    = r_sda_oe;
  assign cmd_byte  = r_cmd_byte;
  assign cmd_valid = r_cmd_valid;
  assign rd_done   = r_rd_done;
  assign busy      = r_busy;

endmodule
